// File: rtl/snake_head_ctrl_pkg.sv
// Shared direction/state encodings and helpers for the snake head controller.
// No logic of its own; latency and backpressure are not applicable.
package snake_head_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    // Opposite direction: flipping bit 1 swaps RIGHT<->LEFT and DOWN<->UP.
    function automatic dir_e dir_reverse(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_head_ctrl_tick_divider.sv
// Movement pacing counter: tc is combinational, high in the last RUN cycle of each period.
// Counts only while run; holds otherwise; clear forces it back to zero.
module snake_head_ctrl_tick_divider #(
    parameter int TICK_DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic tc
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = run && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head sequencer: game FSM, direction latch and wrapping x/y counters.
// Outputs are registered; step pulses one cycle after the divider's terminal count.
module snake_head_ctrl
    import snake_head_ctrl_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int TICK_DIV = 2500000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_start,
    input  logic             game_over,
    input  logic [WIDTH-1:0] max_x,
    input  logic [WIDTH-1:0] max_y,
    output logic [WIDTH-1:0] head_x,
    output logic [WIDTH-1:0] head_y,
    output logic [1:0]       dir,
    output logic             step,
    output logic [1:0]       state
);

    // Wrap-at-max step; a head beyond a shrunken max snaps to max when decrementing.
    function automatic logic [WIDTH-1:0] wrap_step(input logic [WIDTH-1:0] h,
                                                   input logic [WIDTH-1:0] lim,
                                                   input logic             dec);
        if (dec) begin
            return ((h == '0) || (h > lim)) ? lim : h - 1'b1;
        end
        return (h >= lim) ? '0 : h + 1'b1;
    endfunction

    state_e           state_q;
    dir_e             dir_q;
    dir_e             pend_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             step_q;

    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    dir_e             req;
    logic             req_vld;
    logic             req_acc;
    logic             tc;
    logic             step_edge;

    snake_head_ctrl_tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_div (
        .clock  (clock),
        .reset_n(reset_n),
        .run    (state_q == ST_RUN),
        .clear  ((state_q == ST_IDLE) || game_over),
        .tc     (tc)
    );

    assign step_edge = tc && !game_over;

    always_comb begin
        req_vld = 1'b1;
        req     = DIR_RIGHT;
        if (btn_up) begin
            req = DIR_UP;
        end else if (btn_down) begin
            req = DIR_DOWN;
        end else if (btn_left) begin
            req = DIR_LEFT;
        end else if (btn_right) begin
            req = DIR_RIGHT;
        end else begin
            req_vld = 1'b0;
        end
    end

    // Reversal check is against the committed direction, even on a step edge.
    assign req_acc = req_vld && (state_q != ST_PAUSE) && (req != dir_reverse(dir_q));

    // The head moves in the direction being committed this step, i.e. pend_q.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        case (pend_q)
            DIR_RIGHT: x_d = wrap_step(x_q, max_x, 1'b0);
            DIR_LEFT:  x_d = wrap_step(x_q, max_x, 1'b1);
            DIR_DOWN:  y_d = wrap_step(y_q, max_y, 1'b0);
            DIR_UP:    y_d = wrap_step(y_q, max_y, 1'b1);
            default:   x_d = x_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            x_q     <= '0;
            y_q     <= '0;
            step_q  <= 1'b0;
        end else if (game_over) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            x_q     <= '0;
            y_q     <= '0;
            step_q  <= 1'b0;
        end else begin
            step_q <= step_edge;
            case (state_q)
                ST_IDLE:  if (btn_start) state_q <= ST_RUN;
                ST_RUN:   if (btn_start) state_q <= ST_PAUSE;
                ST_PAUSE: if (btn_start) state_q <= ST_RUN;
                default:  state_q <= ST_IDLE;
            endcase
            if (step_edge) begin
                dir_q <= pend_q;
                x_q   <= x_d;
                y_q   <= y_d;
            end
            if (req_acc) begin
                pend_q <= req;
            end
        end
    end

    assign head_x = x_q;
    assign head_y = y_q;
    assign dir    = dir_q;
    assign step   = step_q;
    assign state  = state_q;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed bench for snake_head_ctrl with TICK_DIV=4, WIDTH=5.
module tb_snake_head_ctrl;

    localparam int WIDTH = 5;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             btn_up, btn_down, btn_left, btn_right, btn_start;
    logic             game_over;
    logic [WIDTH-1:0] max_x, max_y;
    logic [WIDTH-1:0] head_x, head_y;
    logic [1:0]       dir;
    logic             step;
    logic [1:0]       state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    snake_head_ctrl #(
        .WIDTH   (WIDTH),
        .TICK_DIV(4)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_start(btn_start),
        .game_over(game_over),
        .max_x    (max_x),
        .max_y    (max_y),
        .head_x   (head_x),
        .head_y   (head_y),
        .dir      (dir),
        .step     (step),
        .state    (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // b = {up, down, left, right, start}, held for exactly one clock edge
    task automatic pulse(input logic [4:0] b);
        {btn_up, btn_down, btn_left, btn_right, btn_start} = b;
        tick();
        {btn_up, btn_down, btn_left, btn_right, btn_start} = '0;
    endtask

    task automatic finish_step(input int n);
        repeat (n - 1) tick();
        chk("step_low_before", {31'd0, step}, 32'd0);
        tick();
        chk("step_pulse", {31'd0, step}, 32'd1);
    endtask

    task automatic head_is(input string tag, input int x, input int y, input int d);
        chk({tag, "_x"}, {27'd0, head_x}, x);
        chk({tag, "_y"}, {27'd0, head_y}, y);
        chk({tag, "_dir"}, {30'd0, dir}, d);
    endtask

    initial begin
        int saw_step;
        reset_n = 1'b0;
        {btn_up, btn_down, btn_left, btn_right, btn_start} = '0;
        game_over = 1'b0;
        max_x = 5'd31;
        max_y = 5'd31;
        tick();
        tick();
        reset_n = 1'b1;
        head_is("reset", 0, 0, 0);
        chk("reset_state", {30'd0, state}, 0);
        chk("reset_step", {31'd0, step}, 0);

        // Start, free run to the right
        pulse(5'b00001);
        chk("run_state", {30'd0, state}, 1);
        finish_step(4);
        head_is("step1", 1, 0, 0);
        tick();
        chk("step_one_cycle", {31'd0, step}, 0);
        finish_step(3);
        head_is("step2", 2, 0, 0);
        finish_step(4);
        head_is("step3", 3, 0, 0);
        repeat (28) finish_step(4);
        head_is("x31", 31, 0, 0);
        finish_step(4);
        head_is("wrap_right", 0, 0, 0);

        // Shrunken max with head beyond it wraps to 0
        repeat (12) finish_step(4);
        chk("x12", {27'd0, head_x}, 12);
        max_x = 5'd9;
        finish_step(4);
        chk("shrink_wrap", {27'd0, head_x}, 0);
        max_x = 5'd31;

        // max changes between step edges are not sampled
        tick();
        max_x = 5'd0;
        tick();
        max_x = 5'd31;
        finish_step(2);
        chk("max_glitch", {27'd0, head_x}, 1);

        // Reverse request dropped
        pulse(5'b00100);
        finish_step(3);
        head_is("rev_drop", 2, 0, 0);
        // UP beats LEFT; y wraps 0 -> 31
        pulse(5'b10100);
        finish_step(3);
        head_is("up_prio", 2, 31, 3);
        // Last accepted press wins
        pulse(5'b00100);
        pulse(5'b00010);
        finish_step(2);
        head_is("last_wins", 3, 31, 0);
        pulse(5'b01000);
        finish_step(3);
        head_is("down_wrap", 3, 0, 1);
        pulse(5'b00100);
        finish_step(3);
        head_is("left1", 2, 0, 2);
        finish_step(4);
        finish_step(4);
        chk("x0", {27'd0, head_x}, 0);
        finish_step(4);
        head_is("wrap_left", 31, 0, 2);
        max_x = 5'd9;
        finish_step(4);
        chk("dec_above_max", {27'd0, head_x}, 9);

        // Press on the step edge applies to the following step
        repeat (3) tick();
        btn_up = 1'b1;
        tick();
        btn_up = 1'b0;
        chk("edge_step", {31'd0, step}, 1);
        head_is("edge_press", 8, 0, 2);
        finish_step(4);
        head_is("edge_next", 8, 31, 3);

        // Pause: frozen, buttons ignored, divider held
        pulse(5'b00001);
        chk("pause_state", {30'd0, state}, 2);
        saw_step = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) btn_left = 1'b1;
            if (i == 5) btn_down = 1'b1;
            tick();
            btn_left = 1'b0;
            btn_down = 1'b0;
            if (step) saw_step++;
        end
        chk("pause_no_step", saw_step, 0);
        head_is("pause_frozen", 8, 31, 3);
        chk("pause_hold", {30'd0, state}, 2);
        pulse(5'b00001);
        chk("resume_state", {30'd0, state}, 1);
        finish_step(3);
        head_is("resume", 8, 30, 3);

        // game_over beats start
        tick();
        game_over = 1'b1;
        btn_start = 1'b1;
        tick();
        game_over = 1'b0;
        btn_start = 1'b0;
        head_is("gameover", 0, 0, 0);
        chk("gameover_state", {30'd0, state}, 0);
        chk("gameover_step", {31'd0, step}, 0);
        saw_step = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (step) saw_step++;
        end
        chk("idle_no_step", saw_step, 0);
        chk("idle_hold", {30'd0, state}, 0);
        pulse(5'b00001);
        finish_step(4);
        head_is("restart_pend_cleared", 1, 0, 0);

        // Reset at divider==3 suppresses the step
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        head_is("midreset", 0, 0, 0);
        chk("midreset_state", {30'd0, state}, 0);
        chk("midreset_step", {31'd0, step}, 0);
        reset_n = 1'b1;
        tick();
        chk("post_reset_step", {31'd0, step}, 0);
        chk("post_reset_state", {30'd0, state}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
